// File: rtl/core_mem_arbiter_if.sv
// Core-side instruction/data request ports and the shared memory port
// of the core memory arbiter, bundled for module-port use.
interface core_mem_arbiter_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_err;
    logic [63:0] imem_rdata;

    logic        dmem_req;
    logic [63:0] dmem_addr;
    logic        dmem_wen;
    logic [7:0]  dmem_strb;
    logic [63:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_err;
    logic [63:0] dmem_rdata;

    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [7:0]  mem_strb;
    logic [63:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_err;
    logic [63:0] mem_rdata;

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_err,
        output imem_rdata,
        input  dmem_req,
        input  dmem_addr,
        input  dmem_wen,
        input  dmem_strb,
        input  dmem_wdata,
        output dmem_gnt,
        output dmem_err,
        output dmem_rdata,
        output mem_req,
        output mem_addr,
        output mem_wen,
        output mem_strb,
        output mem_wdata,
        input  mem_gnt,
        input  mem_err,
        input  mem_rdata
    );

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_err,
        input  imem_rdata,
        output dmem_req,
        output dmem_addr,
        output dmem_wen,
        output dmem_strb,
        output dmem_wdata,
        input  dmem_gnt,
        input  dmem_err,
        input  dmem_rdata,
        input  mem_req,
        input  mem_addr,
        input  mem_wen,
        input  mem_strb,
        input  mem_wdata,
        output mem_gnt,
        output mem_err,
        output mem_rdata
    );
endinterface

// File: rtl/core_mem_arbiter.sv
// Two-port (instruction/data) arbiter onto one shared memory port, with
// request locking while stalled and instruction-fetch starvation relief.
module core_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic g_clk,
    input  logic g_resetn,
    core_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_I    = 2'd1,
        SEL_D    = 2'd2
    } sel_e;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    state_e     state_q;
    state_e     state_d;
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;
    logic       rsp_valid_q;
    logic       rsp_valid_d;
    logic       rsp_owner_q;
    logic       rsp_owner_d;

    sel_e       sel;
    logic       starve;
    logic       sel_req;
    logic       gnt_i;
    logic       gnt_d;

    assign starve = (cnt_q == LIMIT);

    // Once locked, the stalled port keeps the bus so its fields stay stable.
    always_comb begin
        sel = SEL_NONE;
        unique case (state_q)
            LOCK_I: sel = SEL_I;
            LOCK_D: sel = SEL_D;
            default: begin
                if (bus.dmem_req && !(bus.imem_req && starve))
                    sel = SEL_D;
                else if (bus.imem_req)
                    sel = SEL_I;
            end
        endcase
    end

    always_comb begin
        sel_req       = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wen   = 1'b0;
        bus.mem_strb  = '0;
        bus.mem_wdata = '0;
        unique case (sel)
            SEL_I: begin
                sel_req      = bus.imem_req;
                bus.mem_addr = bus.imem_addr;
            end
            SEL_D: begin
                sel_req       = bus.dmem_req;
                bus.mem_addr  = bus.dmem_addr;
                bus.mem_wen   = bus.dmem_wen;
                bus.mem_strb  = bus.dmem_strb;
                bus.mem_wdata = bus.dmem_wdata;
            end
            default: ;
        endcase
    end

    assign bus.mem_req = sel_req;

    assign gnt_i = bus.mem_gnt && (sel == SEL_I) && bus.imem_req;
    assign gnt_d = bus.mem_gnt && (sel == SEL_D) && bus.dmem_req;

    assign bus.imem_gnt = gnt_i;
    assign bus.dmem_gnt = gnt_d;

    assign bus.imem_rdata = bus.mem_rdata;
    assign bus.dmem_rdata = bus.mem_rdata;

    // Owner 0 is the instruction port, 1 the data port.
    assign bus.imem_err = bus.mem_err && rsp_valid_q && !rsp_owner_q;
    assign bus.dmem_err = bus.mem_err && rsp_valid_q && rsp_owner_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOCK_I: begin
                if (bus.mem_gnt || !bus.imem_req)
                    state_d = IDLE;
            end
            LOCK_D: begin
                if (bus.mem_gnt || !bus.dmem_req)
                    state_d = IDLE;
            end
            default: begin
                if (sel_req && !bus.mem_gnt) begin
                    if (sel == SEL_I)
                        state_d = LOCK_I;
                    else if (sel == SEL_D)
                        state_d = LOCK_D;
                end
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!bus.imem_req || gnt_i)
            cnt_d = '0;
        else if (cnt_q != LIMIT)
            cnt_d = cnt_q + 3'd1;
    end

    always_comb begin
        rsp_valid_d = sel_req && bus.mem_gnt;
        rsp_owner_d = rsp_owner_q;
        if (rsp_valid_d)
            rsp_owner_d = (sel == SEL_D);
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_owner_q <= rsp_owner_d;
        end
    end

    a_one_grant: assert property (
        @(posedge g_clk) !(gnt_i && gnt_d)
    );

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Scoreboard bench for core_mem_arbiter: directed scenarios followed by
// randomized traffic, checked against a rule-level reference model.
module tb_core_mem_arbiter;

    localparam int LIMIT = 4;

    localparam logic [63:0] A_I = 64'h0000_0000_8000_0100;
    localparam logic [63:0] A_D = 64'h0000_0000_9000_0200;
    localparam logic [63:0] W_D = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [7:0]  S_D = 8'h0F;

    logic g_clk = 1'b0;
    logic g_resetn;

    core_mem_arbiter_if bus();

    core_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .bus      (bus)
    );

    always #5 g_clk = ~g_clk;

    typedef struct {
        logic        ig;
        logic        dg;
        logic        mreq;
        logic [63:0] maddr;
        logic        mwen;
        logic [7:0]  mstrb;
        logic [63:0] mwdata;
        logic        ie;
        logic        de;
        logic [63:0] rdata;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: which port holds the bus (0 none, 1 I, 2 D),
    // how long fetch has waited, and who owns the next response.
    int m_lock  = 0;
    int m_stall = 0;
    bit m_rv    = 1'b0;
    int m_own   = 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge g_clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("imem_gnt",   {63'd0, bus.imem_gnt}, {63'd0, e.ig});
            chk("dmem_gnt",   {63'd0, bus.dmem_gnt}, {63'd0, e.dg});
            chk("mem_req",    {63'd0, bus.mem_req},  {63'd0, e.mreq});
            chk("mem_addr",   bus.mem_addr,          e.maddr);
            chk("mem_wen",    {63'd0, bus.mem_wen},  {63'd0, e.mwen});
            chk("mem_strb",   {56'd0, bus.mem_strb}, {56'd0, e.mstrb});
            chk("mem_wdata",  bus.mem_wdata,         e.mwdata);
            chk("imem_err",   {63'd0, bus.imem_err}, {63'd0, e.ie});
            chk("dmem_err",   {63'd0, bus.dmem_err}, {63'd0, e.de});
            chk("imem_rdata", bus.imem_rdata,        e.rdata);
            chk("dmem_rdata", bus.dmem_rdata,        e.rdata);
        end
    end

    task automatic step(
        input  bit          rst,
        input  bit          ir,
        input  logic [63:0] ia,
        input  bit          dr,
        input  logic [63:0] da,
        input  bit          dw,
        input  logic [7:0]  ds,
        input  logic [63:0] dd,
        input  bit          mg,
        input  bit          me,
        input  logic [63:0] md,
        output bit          ig,
        output bit          dg
    );
        exp_t e;
        int   sel;
        bit   mreq;
        @(posedge g_clk);
        #1;
        g_resetn       = !rst;
        bus.imem_req   = ir;
        bus.imem_addr  = ia;
        bus.dmem_req   = dr;
        bus.dmem_addr  = da;
        bus.dmem_wen   = dw;
        bus.dmem_strb  = ds;
        bus.dmem_wdata = dd;
        bus.mem_gnt    = mg;
        bus.mem_err    = me;
        bus.mem_rdata  = md;

        sel = 0;
        if (m_lock != 0)
            sel = m_lock;
        else if (dr && !(ir && m_stall == LIMIT))
            sel = 2;
        else if (ir)
            sel = 1;
        mreq = (sel == 1 && ir) || (sel == 2 && dr);

        e.mreq   = mreq;
        e.maddr  = (sel == 1) ? ia : (sel == 2) ? da : 64'd0;
        e.mwen   = (sel == 2) ? dw : 1'b0;
        e.mstrb  = (sel == 2) ? ds : 8'd0;
        e.mwdata = (sel == 2) ? dd : 64'd0;
        e.ig     = mg && sel == 1 && ir;
        e.dg     = mg && sel == 2 && dr;
        e.ie     = me && m_rv && m_own == 1;
        e.de     = me && m_rv && m_own == 2;
        e.rdata  = md;
        exp_q.push_back(e);
        ig = e.ig;
        dg = e.dg;

        if (rst) begin
            m_lock  = 0;
            m_stall = 0;
            m_rv    = 1'b0;
            m_own   = 1;
        end else begin
            if (m_lock == 0) begin
                if (sel != 0 && mreq && !mg)
                    m_lock = sel;
            end else if (mg || !mreq) begin
                m_lock = 0;
            end
            if (!ir || e.ig)
                m_stall = 0;
            else if (m_stall < LIMIT)
                m_stall++;
            m_rv = mreq && mg;
            if (m_rv)
                m_own = sel;
        end
    endtask

    task automatic cyc(input bit rst, input bit ir, input bit dr,
                       input bit mg, input bit me);
        bit ig;
        bit dg;
        step(rst, ir, A_I, dr, A_D, 1'b1, S_D, W_D, mg, me,
             {$urandom, $urandom}, ig, dg);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit          ip;
        bit          dp;
        logic [63:0] ia;
        logic [63:0] da;
        logic [63:0] dd;
        bit          dw;
        logic [7:0]  ds;
        bit          ig;
        bit          dg;
        bit          rst;

        g_resetn       = 1'b0;
        bus.imem_req   = 1'b0;
        bus.imem_addr  = '0;
        bus.dmem_req   = 1'b0;
        bus.dmem_addr  = '0;
        bus.dmem_wen   = 1'b0;
        bus.dmem_strb  = '0;
        bus.dmem_wdata = '0;
        bus.mem_gnt    = 1'b0;
        bus.mem_err    = 1'b0;
        bus.mem_rdata  = '0;
        repeat (3) @(posedge g_clk);

        // quiet after reset, including a stray mem_err
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);

        // both request: data first, error routed to data next cycle
        cyc(0, 1, 1, 1, 0);
        cyc(0, 1, 0, 1, 1);
        cyc(0, 0, 0, 0, 1);

        // starvation: four data grants then one fetch, then data again
        cyc(1, 0, 0, 0, 0);
        repeat (7) cyc(0, 1, 1, 1, 0);

        // fetch locked while stalled, data waits behind it
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 1, 0);
        cyc(0, 0, 1, 1, 0);

        // alternating I, D, I with error only behind the D grant
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 1, 0, 1, 1);
        cyc(0, 0, 0, 0, 0);

        // reset during a data lock suppresses the following error
        cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 1, 0);

        // request dropped while locked releases the lock
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 0);

        ip = 1'b0;
        dp = 1'b0;
        ia = '0;
        da = '0;
        dd = '0;
        dw = 1'b0;
        ds = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!ip && $urandom_range(0, 9) < 6) begin
                ip = 1'b1;
                ia = {$urandom, $urandom};
            end
            if (!dp && $urandom_range(0, 9) < 5) begin
                dp = 1'b1;
                da = {$urandom, $urandom};
                dd = {$urandom, $urandom};
                dw = 1'($urandom_range(0, 1));
                ds = 8'($urandom);
            end
            if (ip && $urandom_range(0, 49) == 0)
                ip = 1'b0;
            if (dp && $urandom_range(0, 49) == 0)
                dp = 1'b0;
            rst = ($urandom_range(0, 99) == 0);
            step(rst, ip, ia, dp, da, dw, ds, dd,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 2) == 0,
                 {$urandom, $urandom}, ig, dg);
            if (ig)
                ip = 1'b0;
            if (dg)
                dp = 1'b0;
        end

        @(posedge g_clk);
        @(negedge g_clk);
        #1;
        chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/core_mem_arbiter.md
CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

Interface
REQ-001 Parameters SHALL be: STARVE_LIMIT, 4, consecutive stalled instruction-port cycles before the instruction port takes priority (range 1-7).
REQ-002 Clock and reset SHALL be g_clk (synchronous, active-low reset g_resetn); all state updates on the g_clk rising edge.
REQ-003 g_clk  input  1  global clock.
REQ-004 g_resetn  input  1  global active-low synchronous reset.
REQ-005 imem_req  input  1  instruction fetch request; held high until imem_gnt.
REQ-006 imem_addr  input  64  instruction fetch address.
REQ-007 imem_gnt  output  1  instruction request accepted this cycle.
REQ-008 imem_err  output  1  instruction response error, valid the cycle after imem_gnt.
REQ-009 imem_rdata  output  64  instruction response data, valid the cycle after imem_gnt.
REQ-010 dmem_req, dmem_addr[64], dmem_wen, dmem_strb[8], dmem_wdata[64]  inputs  data (LSU) request; held stable until dmem_gnt.
REQ-011 dmem_gnt  output  1; dmem_err  output  1; dmem_rdata  output  64  data grant and response, same timing as instruction port.
REQ-012 mem_req  output  1; mem_addr  output  64; mem_wen  output  1; mem_strb  output  8; mem_wdata  output  64  shared memory request.
REQ-013 mem_gnt  input  1; mem_err  input  1; mem_rdata  input  64  shared memory grant and response; response one cycle after mem_req && mem_gnt.

Function
REQ-014 The block SHALL hold a 3-state FSM: IDLE, LOCK_I, LOCK_D.
REQ-015 In IDLE, selection SHALL be: data port if dmem_req && !(imem_req && starve); else instruction port if imem_req; else none.
REQ-016 starve SHALL be 1 exactly when the starvation counter equals STARVE_LIMIT.
REQ-017 In LOCK_I / LOCK_D, selection SHALL be fixed to the locked port regardless of the other port's request or starve.
REQ-018 IDLE -> LOCK_x SHALL occur when port x is selected, mem_req=1 and mem_gnt=0.
REQ-019 LOCK_x -> IDLE SHALL occur on mem_gnt=1, or when port x drops its request (protocol violation; no grant issued to x that cycle).
REQ-020 mem_req SHALL be the selected port's req; mem_addr/mem_wen/mem_strb/mem_wdata SHALL be the selected port's fields; with instruction port selected mem_wen=0, mem_strb=0, mem_wdata=0; with none selected all request outputs SHALL be 0.
REQ-021 imem_gnt SHALL be mem_gnt && instruction selected && imem_req; dmem_gnt SHALL be mem_gnt && data selected && dmem_req; never both in one cycle.
REQ-022 A registered rsp_valid SHALL be set to (mem_req && mem_gnt) each cycle, and rsp_owner SHALL capture the granted port when set.
REQ-023 imem_rdata and dmem_rdata SHALL both equal mem_rdata unconditionally (zero added latency).
REQ-024 imem_err SHALL be mem_err && rsp_valid && rsp_owner==I; dmem_err SHALL be mem_err && rsp_valid && rsp_owner==D.
REQ-025 Back-to-back grants SHALL be supported: a new grant in the same cycle as the previous response, to either port, with correct error routing.
REQ-026 Starvation counter (3 bits) SHALL increment when imem_req && !imem_gnt, saturating at STARVE_LIMIT; clear on imem_gnt or !imem_req.
REQ-027 Data port SHALL retain priority over a starving instruction port while in LOCK_D; starve takes effect only at the next IDLE selection.
REQ-028 Grant and data outputs SHALL be combinational from inputs and state; there is no input-to-grant register stage.

Reset
REQ-029 While g_resetn=0 the block SHALL move FSM to IDLE, clear the counter, and set rsp_valid=0, rsp_owner=I on the next edge.
REQ-030 After reset with no requests, all outputs SHALL be 0 except imem_rdata/dmem_rdata, which follow mem_rdata.
REQ-031 Reset asserted mid-lock SHALL abandon the lock; any in-flight response error of the following cycle SHALL be suppressed (rsp_valid=0).

Verification
REQ-032 Both ports request, mem_gnt=1 constant, counter 0 -> dmem_gnt=1 cycle 0, imem_gnt=0; next cycle dmem_err follows mem_err, imem_err=0.
REQ-033 dmem_req held continuously, imem_req held, mem_gnt=1 every cycle, STARVE_LIMIT=4 -> 4 data grants, then imem_gnt=1 on cycle 4, counter clears, data resumes cycle 5.
REQ-034 imem selected with mem_gnt=0 for 3 cycles while dmem_req rises cycle 1 -> state LOCK_I, mem_addr stays imem_addr, imem_gnt on the cycle mem_gnt=1, dmem granted afterwards.
REQ-035 Alternating grants I,D,I with mem_err=1 only in cycle after the D grant -> only dmem_err=1 that cycle; imem_err=0 throughout.
REQ-036 g_resetn=0 during LOCK_D with mem_gnt=1 same cycle -> next cycle state IDLE, rsp_valid=0, dmem_err=0 despite mem_err=1.
